// File: rtl/cnn_conv_sched.sv
// Convolution window sequencer: latches the mode registers on a start edge and
// walks every (kernel, row, col) window, handing one descriptor at a time to the datapath.
module cnn_conv_sched #(
    parameter int IN_SIZE = 32,
    parameter int COORD_W = 8
) (
    input  logic               clk_a,
    input  logic               arstz_aq,
    input  logic               CMD_START,
    input  logic [7:0]         MODE_KERNEL_SIZE,
    input  logic [7:0]         MODE_KERNEL_NUMS,
    input  logic [1:0]         MODE_STRIDE,
    input  logic               MODE_PADDING,
    output logic               CMD_DONE,
    output logic               CMD_DONE_VALID,
    output logic               win_valid,
    input  logic               win_ready,
    output logic [7:0]         win_kernel,
    output logic [COORD_W-1:0] win_row,
    output logic [COORD_W-1:0] win_col,
    output logic [7:0]         win_pad,
    output logic               win_last,
    input  logic               acc_done,
    output logic               busy
);

    localparam int CW = COORD_W + 2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_NEXT  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    logic [2:0]         state_r, state_s;
    logic               start_q_r;
    logic [7:0]         k_size_r, k_nums_r, pad_r;
    logic [1:0]         stride_r;
    logic [7:0]         k_r, k_s;
    logic [COORD_W-1:0] row_r, row_s, col_r, col_s;
    logic               valid_r, last_r, done_r, done_valid_r, busy_r;
    logic               start_s, reject_s, col_fit_s, row_fit_s, last_s;
    logic [CW-1:0]      ext_s, kx_s, sx_s;

    // A window is final when it is on the last kernel and neither axis can step again.
    function automatic logic is_last(input logic [7:0] k, input logic [CW-1:0] r,
                                     input logic [CW-1:0] c, input logic [7:0] n,
                                     input logic [CW-1:0] s, input logic [CW-1:0] kk,
                                     input logic [CW-1:0] p);
        return (k == (n - 8'd1)) && ((c + s + kk) > p) && ((r + s + kk) > p);
    endfunction

    // Padded extent and window-fit tests, all in CW bits so the sums cannot wrap.
    always_comb begin
        start_s   = CMD_START & ~start_q_r;
        ext_s     = CW'(IN_SIZE) + CW'(pad_r) + CW'(pad_r);
        kx_s      = CW'(k_size_r);
        sx_s      = CW'(stride_r);
        col_fit_s = (CW'(col_r) + sx_s + kx_s) <= ext_s;
        row_fit_s = (CW'(row_r) + sx_s + kx_s) <= ext_s;
        reject_s  = (k_size_r == 8'd0) || (k_nums_r == 8'd0) ||
                    (stride_r == 2'd0) || (kx_s > ext_s);
    end

    // Next-state and counter-advance logic.
    always_comb begin
        state_s = state_r;
        k_s     = k_r;
        row_s   = row_r;
        col_s   = col_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) state_s = ST_CHECK;
                else         state_s = ST_IDLE;
            end
            ST_CHECK: begin
                if (reject_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_ISSUE;
                    k_s     = 8'd0;
                    row_s   = {COORD_W{1'b0}};
                    col_s   = {COORD_W{1'b0}};
                end
            end
            ST_ISSUE: begin
                if (win_ready) state_s = ST_WAIT;
                else           state_s = ST_ISSUE;
            end
            ST_WAIT: begin
                if (acc_done) begin
                    if (last_r) state_s = ST_DONE;
                    else        state_s = ST_NEXT;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_NEXT: begin
                state_s = ST_ISSUE;
                if (col_fit_s) begin
                    col_s = col_r + COORD_W'(stride_r);
                end else begin
                    col_s = {COORD_W{1'b0}};
                    if (row_fit_s) begin
                        row_s = row_r + COORD_W'(stride_r);
                    end else begin
                        row_s = {COORD_W{1'b0}};
                        k_s   = k_r + 8'd1;
                    end
                end
            end
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
        last_s = is_last(k_s, CW'(row_s), CW'(col_s), k_nums_r, sx_s, kx_s, ext_s);
    end

    // State, configuration and output registers.
    always_ff @(posedge clk_a) begin
        if (!arstz_aq) begin
            state_r      <= ST_IDLE;
            start_q_r    <= 1'b0;
            k_size_r     <= 8'd0;
            k_nums_r     <= 8'd0;
            stride_r     <= 2'd0;
            pad_r        <= 8'd0;
            k_r          <= 8'd0;
            row_r        <= {COORD_W{1'b0}};
            col_r        <= {COORD_W{1'b0}};
            valid_r      <= 1'b0;
            last_r       <= 1'b0;
            done_r       <= 1'b0;
            done_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r   <= state_s;
            start_q_r <= CMD_START;
            k_r       <= k_s;
            row_r     <= row_s;
            col_r     <= col_s;
            if ((state_r == ST_IDLE) && start_s) begin
                k_size_r <= MODE_KERNEL_SIZE;
                k_nums_r <= MODE_KERNEL_NUMS;
                stride_r <= MODE_STRIDE;
                pad_r    <= MODE_PADDING ? ((MODE_KERNEL_SIZE - 8'd1) >> 1'b1) : 8'd0;
            end
            valid_r <= (state_s == ST_ISSUE);
            // last is evaluated once on entry to ISSUE and held through WAIT for the exit decision
            if ((state_s == ST_ISSUE) && (state_r != ST_ISSUE)) begin
                last_r <= last_s;
            end else if ((state_s == ST_ISSUE) || (state_s == ST_WAIT)) begin
                last_r <= last_r;
            end else begin
                last_r <= 1'b0;
            end
            done_valid_r <= (state_s == ST_DONE);
            if ((state_s == ST_DONE) && (state_r != ST_DONE)) begin
                done_r <= (state_r == ST_WAIT);
            end
            busy_r <= (state_s != ST_IDLE);
        end
    end

    assign CMD_DONE       = done_r;
    assign CMD_DONE_VALID = done_valid_r;
    assign win_valid      = valid_r;
    assign win_kernel     = k_r;
    assign win_row        = row_r;
    assign win_col        = col_r;
    assign win_pad        = pad_r;
    assign win_last       = last_r;
    assign busy           = busy_r;

endmodule
